// File: rtl/dds_pkg.sv
// Shared constants for the DDS parameter scheduler: FSM encoding, reset defaults, range limits.
package dds_pkg;

  localparam int DEF_FREQ = 100;
  localparam int DEF_AMP  = 20;
  localparam int FTW_MULT = 86;
  localparam int FREQ_MAX = 10000;
  localparam int AMP_MAX  = 99;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHECK     = 3'd1;
  localparam logic [2:0] S_MUL       = 3'd2;
  localparam logic [2:0] S_WAIT_WRAP = 3'd3;
  localparam logic [2:0] S_COMMIT    = 3'd4;

endpackage

// File: rtl/dds_param_sched_serial_mult.sv
// Unsigned bit-serial shift-add multiplier: consumes one bit of i_a per cycle, exactly A_W cycles.
// o_done flags the final step; o_product holds the full result from the following cycle.
module serial_mult #(
  parameter int A_W = 17,
  parameter int B_W = 7,
  parameter int P_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  output logic           o_done,
  output logic [P_W-1:0] o_product
);
  localparam int CNT_W = $clog2(A_W + 1);

  logic [A_W-1:0]   r_mplier;
  logic [P_W-1:0]   r_mcand;
  logic [P_W-1:0]   r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             w_last;

  assign w_last = r_run && (r_cnt == CNT_W'(A_W - 1));

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mplier <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_start) begin
      r_mplier <= i_a;
      r_mcand  <= P_W'(i_b);
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mplier <= r_mplier >> 1;
      r_mcand  <= r_mcand << 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) r_run <= 1'b0;
    end
  end

  assign o_done    = w_last;
  assign o_product = r_acc;

endmodule

// File: rtl/dds_param_sched.sv
// Range-checks freq/amp requests, converts Hz to a DDS tuning word and commits it glitch-free.
// Define DDS_PARAM_BOUNDARY_SYNC_EN to hold each commit until a DDS phase wrap (or timeout).
module dds_param_sched
  import dds_pkg::*;
#(
  parameter int FREQ_W       = 17,
  parameter int AMP_W        = 17,
  parameter int PHASE_W      = 32,
  parameter int FTW_MULT     = dds_pkg::FTW_MULT,
  parameter int FREQ_MAX     = dds_pkg::FREQ_MAX,
  parameter int AMP_MAX      = dds_pkg::AMP_MAX,
  parameter int WRAP_TIMEOUT = 1048575
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_sig,
  input  logic [FREQ_W-1:0]  freq_in,
  input  logic [AMP_W-1:0]   amp_in,
  input  logic               dds_wrap,
  output logic [PHASE_W-1:0] ftw,
  output logic [AMP_W-1:0]   amp_out,
  output logic               commit,
  output logic               range_err,
  output logic               busy
);
  localparam int MULT_W = $clog2(FTW_MULT + 1);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [FREQ_W-1:0]  r_req_freq;
  logic [AMP_W-1:0]   r_req_amp;
  logic [FREQ_W-1:0]  r_pend_freq;
  logic [AMP_W-1:0]   r_pend_amp;
  logic               r_pend_valid;
  logic [PHASE_W-1:0] r_ftw;
  logic [AMP_W-1:0]   r_amp;
  logic               r_commit;
  logic               w_idle;
  logic               w_req_bad;
  logic               w_mult_start;
  logic               w_mult_done;
  logic               w_wait_done;
  logic [PHASE_W-1:0] w_product;

  assign w_idle    = (r_state == S_IDLE);
  assign w_req_bad = (r_req_freq == '0)
                  || (r_req_freq > FREQ_W'(FREQ_MAX))
                  || (r_req_amp  > AMP_W'(AMP_MAX));

  // A queued request is served before a frame arriving in the same IDLE cycle; that frame queues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_freq   <= '0;
      r_req_amp    <= '0;
      r_pend_freq  <= '0;
      r_pend_amp   <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_idle) begin
        if (r_pend_valid) begin
          r_req_freq <= r_pend_freq;
          r_req_amp  <= r_pend_amp;
        end else if (frame_sig) begin
          r_req_freq <= freq_in;
          r_req_amp  <= amp_in;
        end
      end
      if (frame_sig && (!w_idle || r_pend_valid)) begin
        r_pend_freq  <= freq_in;
        r_pend_amp   <= amp_in;
        r_pend_valid <= 1'b1;
      end else if (w_idle) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

`ifdef DDS_PARAM_BOUNDARY_SYNC_EN
  localparam int TMR_W = $clog2(WRAP_TIMEOUT + 1);

  logic [TMR_W-1:0] r_timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_timer <= '0;
    else if (r_state == S_WAIT_WRAP) r_timer <= r_timer + TMR_W'(1);
    else                             r_timer <= '0;
  end

  assign w_wait_done = dds_wrap || (r_timer == TMR_W'(WRAP_TIMEOUT));
`else
  logic w_unused;

  assign w_wait_done = 1'b0;
  assign w_unused    = dds_wrap & (WRAP_TIMEOUT > 0) & w_wait_done;
`endif

  // NOTE: defaults assigned first so every path drives every output -- no latches inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_mult_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_valid || frame_sig) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_req_bad) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt  = S_MUL;
          w_mult_start = 1'b1;
        end
      end
      S_MUL: begin
`ifdef DDS_PARAM_BOUNDARY_SYNC_EN
        if (w_mult_done) w_state_nxt = S_WAIT_WRAP;
`else
        if (w_mult_done) w_state_nxt = S_COMMIT;
`endif
      end
`ifdef DDS_PARAM_BOUNDARY_SYNC_EN
      S_WAIT_WRAP: begin
        if (w_wait_done) w_state_nxt = S_COMMIT;
      end
`endif
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  serial_mult #(
    .A_W (FREQ_W),
    .B_W (MULT_W),
    .P_W (PHASE_W)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mult_start),
    .i_a       (r_req_freq),
    .i_b       (MULT_W'(FTW_MULT)),
    .o_done    (w_mult_done),
    .o_product (w_product)
  );

  // commit is registered alongside ftw/amp_out so the pulse lines up with the new values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ftw    <= PHASE_W'(DEF_FREQ * FTW_MULT);
      r_amp    <= AMP_W'(DEF_AMP);
      r_commit <= 1'b0;
    end else begin
      r_commit <= (r_state == S_COMMIT);
      if (r_state == S_COMMIT) begin
        r_ftw <= w_product;
        r_amp <= r_req_amp;
      end
    end
  end

  assign ftw       = r_ftw;
  assign amp_out   = r_amp;
  assign commit    = r_commit;
  assign range_err = (r_state == S_CHECK) && w_req_bad;
  assign busy      = !w_idle || r_pend_valid;

endmodule

// File: tb/tb_dds_param_sched.sv
// Self-checking bench for dds_param_sched: transaction-timing model compared every cycle,
// plus literal expectations for latency and committed values.
module tb_dds_param_sched;

  localparam int TIMEOUT = 64;
`ifdef DDS_PARAM_BOUNDARY_SYNC_EN
  localparam bit SYNC       = 1'b1;
  localparam int LAT_WRAP5  = 25;
  localparam int LAT_NOWRAP = 21 + TIMEOUT;
  localparam int LAT_FIRST  = 21;
`else
  localparam bit SYNC       = 1'b0;
  localparam int LAT_WRAP5  = 20;
  localparam int LAT_NOWRAP = 20;
  localparam int LAT_FIRST  = 20;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_sig = 1'b0;
  logic [16:0] freq_in = '0;
  logic [16:0] amp_in = '0;
  logic        dds_wrap = 1'b0;
  logic [31:0] ftw;
  logic [16:0] amp_out;
  logic        commit;
  logic        range_err;
  logic        busy;

  dds_param_sched #(.WRAP_TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_sig (frame_sig),
    .freq_in   (freq_in),
    .amp_in    (amp_in),
    .dds_wrap  (dds_wrap),
    .ftw       (ftw),
    .amp_out   (amp_out),
    .commit    (commit),
    .range_err (range_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a request accepted at cycle s shows range_err at s+1 (bad) or its commit at s+20,
  // or, with wrap sync, two cycles after the first wrap at/after s+19 (or after the timeout).
  int     cyc = 0;
  bit     m_svc = 0, m_bad = 0, m_pend = 0;
  int     m_s = 0, m_freq = 0, m_areq = 0, m_done_n = -1, m_commit_n = -1;
  int     m_pf = 0, m_pa = 0;
  longint m_ftw = 8600, m_amp = 20;
  int     dut_commits = 0, dut_errs = 0, dut_commit_n = 0, frame_n = 0;

  task automatic m_start(input int f, input int a);
    m_svc    = 1;
    m_s      = cyc;
    m_freq   = f;
    m_areq   = a;
    m_bad    = (f == 0) || (f > 10000) || (a > 99);
    m_done_n = m_bad ? cyc + 2 : (SYNC ? -1 : cyc + 20);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_svc = 0; m_pend = 0; m_ftw = 8600; m_amp = 20; m_commit_n = -1;
    end else if (m_svc && m_done_n == cyc) begin
      m_svc = 0;
      if (!m_bad) begin
        m_ftw      = (longint'(m_freq) * 86) & 64'hFFFF_FFFF;
        m_amp      = m_areq;
        m_commit_n = cyc;
      end
    end
    check("ftw", ftw, m_ftw);
    check("amp_out", amp_out, m_amp);
    check("commit", commit, m_commit_n == cyc);
    check("range_err", range_err, !rst && m_svc && m_bad && cyc == m_s + 1);
    check("busy", busy, !rst && ((m_svc && cyc > m_s) || m_pend));
    if (commit) begin dut_commits++; dut_commit_n = cyc; end
    if (range_err) dut_errs++;
    if (frame_sig) frame_n = cyc;
    if (!rst) begin
      if (SYNC && m_svc && !m_bad && m_done_n < 0 && cyc >= m_s + 19 &&
          (dds_wrap || (cyc - (m_s + 19)) == TIMEOUT))
        m_done_n = cyc + 2;
      if (!m_svc) begin
        if (m_pend) begin
          m_start(m_pf, m_pa);
          m_pend = frame_sig;
          if (frame_sig) begin m_pf = int'(freq_in); m_pa = int'(amp_in); end
        end else if (frame_sig) begin
          m_start(int'(freq_in), int'(amp_in));
        end
      end else if (frame_sig) begin
        m_pend = 1; m_pf = int'(freq_in); m_pa = int'(amp_in);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  task automatic send(input int f, input int a);
    frame_sig = 1'b1;
    freq_in   = f[16:0];
    amp_in    = a[16:0];
    tick();
    frame_sig = 1'b0;
  endtask

  task automatic pulse_wrap();
    dds_wrap = 1'b1;
    tick();
    dds_wrap = 1'b0;
  endtask

  task automatic wait_commits(input int target, input string name);
    int k = 0;
    while (dut_commits < target && k < 400) begin
      tick();
      k++;
    end
    check(name, dut_commits, target);
  endtask

  int base;

  initial begin
    idle(2);
    rst = 1'b0;
    check("reset_ftw", ftw, 8600);
    check("reset_amp", amp_out, 20);
    check("reset_commit", commit, 0);
    check("reset_busy", busy, 0);
    idle(2);

    // Wrap during MUL must be ignored; wrap 5 cycles after MUL ends releases the commit.
    base = dut_commits;
    send(1000, 50);
    idle(9);
    pulse_wrap();
    idle(12);
    pulse_wrap();
    wait_commits(base + 1, "t1_commit_seen");
    check("t1_latency", dut_commit_n - frame_n, LAT_WRAP5);
    check("t1_ftw", ftw, 86000);
    check("t1_amp", amp_out, 50);
    idle(3);

    // Out-of-range requests: no commit, outputs held.
    base = dut_errs;
    send(12000, 10); idle(4);
    send(500, 100);  idle(4);
    send(0, 10);     idle(4);
    check("t2_range_errs", dut_errs - base, 3);
    check("t2_ftw_held", ftw, 86000);
    check("t2_amp_held", amp_out, 50);

    // Upper boundary accepted; without wraps the sync build falls back to the timeout.
    base = dut_commits;
    send(10000, 99);
    wait_commits(base + 1, "t3_commit_seen");
    check("t3_latency", dut_commit_n - frame_n, LAT_NOWRAP);
    check("t3_ftw", ftw, 860000);
    check("t3_amp", amp_out, 99);
    idle(3);

    // Lower boundary, wrap on the first cycle after MUL.
    base = dut_commits;
    send(1, 0);
    idle(18);
    pulse_wrap();
    wait_commits(base + 1, "t4_commit_seen");
    check("t4_latency", dut_commit_n - frame_n, LAT_FIRST);
    check("t4_ftw", ftw, 86);
    check("t4_amp", amp_out, 0);
    idle(3);

    // Three frames while busy: only the last one is kept.
    base = dut_commits;
    send(500, 30);
    idle(4);
    send(200, 11);
    send(300, 12);
    send(400, 40);
    wait_commits(base + 2, "t5_commits_seen");
    idle(30);
    check("t5_commit_count", dut_commits - base, 2);
    check("t5_ftw", ftw, 34400);
    check("t5_amp", amp_out, 40);
    check("t5_busy", busy, 0);

    // Reset mid-MUL with a pending request: everything discarded.
    base = dut_commits;
    send(700, 70);
    idle(4);
    send(800, 80);
    idle(2);
    rst = 1'b1;
    tick();
    check("t6_rst_ftw", ftw, 8600);
    check("t6_rst_amp", amp_out, 20);
    check("t6_rst_busy", busy, 0);
    rst = 1'b0;
    idle(120);
    check("t6_no_commit", dut_commits - base, 0);
    check("t6_ftw_after", ftw, 8600);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
